// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: N-bit add (a + b + cin) on one 2-bit adder slice, two bits per clock, LSB first.
// Latency: start accepted in IDLE, busy for N/2 cycles, then a one-cycle done with sum/cout valid.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) in RUN or DONE.
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Reject odd or too-small widths at elaboration time.
  generate
    if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
      $error("serial_adder_ctrl: N must be even and >= 2");
    end
  endgenerate

  localparam int HALF = N / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_a_sh;
  logic [N-1:0]  r_b_sh;
  logic [N-1:0]  r_sum_sh;
  logic [N-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_slice;
  logic          w_c1;
  logic          w_last;
  logic [N+1:0]  w_sum_cat;
  logic [N-1:0]  w_sum_nxt;

  // The single 2-bit adder slice: {c1,s1,s0} = a_sh[1:0] + b_sh[1:0] + carry.
  assign w_slice = {1'b0, r_a_sh[1:0]} + {1'b0, r_b_sh[1:0]} + {2'b00, r_carry};
  assign w_c1    = w_slice[2];
  assign w_last  = (r_cnt == LAST_CNT);

  // New slice bits enter at the MSB end while the partial sum shifts right by two;
  // concatenating first keeps this valid for N=2, where there are no old bits left.
  assign w_sum_cat = {w_slice[1:0], r_sum_sh};
  assign w_sum_nxt = w_sum_cat[N+1:2];

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Serial datapath: load on accepted start, one slice step per RUN cycle, and
  // publish sum/cout only on the final step so partial results never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_sum_sh <= '0;
          end
        end
        RUN: begin
          r_sum_sh <= w_sum_nxt;
          r_carry  <= w_c1;
          r_a_sh   <= r_a_sh >> 2;
          r_b_sh   <= r_b_sh >> 2;
          if (w_last) begin
            // Hold the counter on the final step so it never wraps.
            r_sum  <= w_sum_nxt;
            r_cout <= w_c1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequential controller that computes an N-bit sum by time-sharing a single combinational 2-bit adder slice (a1,a0,b1,b0,c0 -> c1,s1,s0), processing two bits per clock from LSB to MSB. It latches operands on a start request, sequences N/2 slice operations while carrying the slice carry-out through a register, and presents the registered sum and carry-out with a one-cycle done pulse. It sits between operand sources (switch/register inputs) and the team's 2-bit adder slice, replacing a wide ripple adder with an area-cheap serial datapath.

## Interface
- N, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  N  operand A, latched on accepted start
- b  input  N  operand B, latched on accepted start
- cin  input  1  carry-in, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  N  registered result, held until next accepted start
- cout  output  1  registered final carry, held with sum

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 at clk edge -> load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0; go RUN. start=0 -> stay.
- RUN, each edge: slice inputs are a_sh[1:0], b_sh[1:0], carry. Update:
  - sum_sh <= {s1, s0, sum_sh[N-1:2]} (results enter at MSB end, shift right)
  - carry <= c1
  - a_sh, b_sh shift right by 2 (zero fill)
  - cnt <= cnt+1; when cnt == N/2-1 -> go DONE.
- DONE: done=1 for exactly one cycle; sum = sum_sh, cout = carry; next state IDLE unconditionally.
- Counter width: clog2(N/2), minimum 1 bit; never wraps during a valid operation.
- sum/cout are the final register values; intermediate shift contents never appear on sum (sum and cout are updated only on the RUN->DONE transition).
- start while in RUN or DONE: ignored, no effect on operands or result; not queued.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(N+1); unsigned.
- Slice may be the existing 2-bit adder module instantiated once, or an equivalent combinational expression; exactly one slice instance.

## Timing
- Reset (rst=1 at edge): state IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, carry=0, shift registers 0. Reset has priority over all other activity, including mid-RUN and DONE; operation in progress is discarded, no done pulse.
- Latency: start high in cycle 0 (IDLE) -> busy high cycles 1..N/2 -> done high in cycle N/2+1 with sum/cout valid from that cycle.
- N=8: RUN 4 cycles, done in cycle 5. N=2: RUN 1 cycle, done in cycle 2.
- Throughput: start held high continuously -> one operation accepted every N/2+2 cycles (next accept in IDLE cycle after DONE).
- done and busy never high simultaneously; busy deasserts in the same cycle done asserts.
- Operand inputs a, b, cin may change freely after the accepting edge without affecting the result.

## Test plan
- N=8, reset then a=0x3B, b=0x2A, cin=1, start pulse in cycle 0 -> busy cycles 1-4, done cycle 5, sum=0x66, cout=0.
- N=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 at done; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- N=8, start accepted with a=0x10, b=0x20; in cycle 2 drive start=1, a=0xFF, b=0xFF -> ignored; done cycle 5 with sum=0x30, cout=0; sum stays 0x30 while idle.
- N=8, start accepted, assert rst in cycle 3 -> next cycle busy=0, done=0, sum=0, cout=0, no done pulse; fresh start with a=0x05, b=0x03, cin=0 -> sum=0x08 after N/2+1 cycles.
- N=8, start held high 20 cycles with a=0x01, b=0x01, cin=0 -> done pulses in cycles 5, 11, 17; sum=0x02 each time.
- N=2 instance, a=3, b=2, cin=1 -> busy cycle 1, done cycle 2, sum=2, cout=1.
